alu_execute_unit: RTL and testbench

- Execute-stage arithmetic block of the 16-bit pipelined processor.
- Decodes the 4-bit opcode and 3-bit function field into a 3-bit ALU operation, selects operands, and computes a 16-bit result plus a zero flag.
- Provides the PC+1 incrementer used for sequential fetch and the call return address.
- The result and flag are also latched into the EX/MEM stage register.

---
 rtl/alu_execute_if.sv | 26 ++
 rtl/alu_execute_unit.sv | 51 +++++
 tb/tb_alu_execute_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_execute_if.sv
// alu_execute_if: operand, control and result bundle of the execute stage
interface alu_execute_if #(parameter int WIDTH = 16);
  logic             en;
  logic [3:0]       Op;
  logic [2:0]       func;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [WIDTH-1:0] ext_imm;
  logic             alu_src;
  logic             for_op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             zero;
  logic [WIDTH-1:0] alu_y_q;
  logic             zero_q;
  modport master (
    output en, Op, func, bus_a, bus_b, ext_imm, alu_src, for_op, pc,
    input  next_pc, alu_op, alu_y, zero, alu_y_q, zero_q
  );
  modport slave (
    input  en, Op, func, bus_a, bus_b, ext_imm, alu_src, for_op, pc,
    output next_pc, alu_op, alu_y, zero, alu_y_q, zero_q
  );
endinterface

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: opcode decode, ALU, PC incrementer and EX/MEM result register
module alu_execute_unit #(parameter int WIDTH = 16) (
  input logic          CLK,
  input logic          RST,
  alu_execute_if.slave io
);
  logic [WIDTH-1:0] op1, op2;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  always_comb begin
    case (io.Op)
      4'b0000: alu_op = (io.func == 3'b111) ? 3'b001 : io.func;
      4'b0001: alu_op = 3'b000;
      4'b0101,
      4'b0110: alu_op = 3'b010;
      4'b1000: alu_op = 3'b111;
      default: alu_op = 3'b001;
    endcase
  end
  assign op1 = io.for_op ? '1 : io.bus_a;
  assign op2 = io.alu_src ? io.ext_imm : io.bus_b;
  always_comb begin
    case (alu_op)
      3'b000:  alu_y = op1 & op2;
      3'b001:  alu_y = op1 + op2;
      3'b010:  alu_y = op1 - op2;
      3'b011:  alu_y = op1 << op2[3:0];
      3'b100:  alu_y = op1 >> op2[3:0];
      3'b101:  alu_y = op1 | op2;
      3'b110:  alu_y = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      default: alu_y = op2;
    endcase
  end
  assign io.alu_op  = alu_op;
  assign io.alu_y   = alu_y;
  assign io.zero    = (alu_y == '0);
  assign io.next_pc = io.pc + 1'b1;
  logic [WIDTH-1:0] y_q;
  logic             z_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q <= '0;
      z_q <= 1'b0;
    end else if (io.en) begin
      y_q <= alu_y;
      z_q <= (alu_y == '0);
    end
  end
  assign io.alu_y_q = y_q;
  assign io.zero_q  = z_q;
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: directed vectors with hand-computed results for the execute stage
module tb_alu_execute_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  alu_execute_if io ();
  alu_execute_unit dut (.CLK(clk), .RST(rst), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic [2:0] fn, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic src, input logic fo);
    io.Op = op; io.func = fn; io.bus_a = a; io.bus_b = b;
    io.ext_imm = imm; io.alu_src = src; io.for_op = fo;
    #1;
  endtask
  task automatic step(input string tag, input logic [3:0] op, input logic [2:0] fn,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                      input logic src, input logic fo, input logic [2:0] exp_op,
                      input logic [15:0] exp_y, input logic exp_z);
    drive(op, fn, a, b, imm, src, fo);
    check({tag, " alu_op"}, {13'd0, io.alu_op}, {13'd0, exp_op});
    check({tag, " alu_y"}, io.alu_y, exp_y);
    check({tag, " zero"}, {15'd0, io.zero}, {15'd0, exp_z});
    @(posedge clk); #1;
    check({tag, " alu_y_q"}, io.alu_y_q, exp_y);
    check({tag, " zero_q"}, {15'd0, io.zero_q}, {15'd0, exp_z});
  endtask
  initial begin
    io.en = 1'b1; io.pc = 16'h0000;
    drive(4'b0000, 3'b001, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset alu_y_q", io.alu_y_q, 16'h0000);
      check("reset zero_q", {15'd0, io.zero_q}, 16'h0000);
      check("reset live alu_y", io.alu_y, 16'h1234);
    end
    rst = 1'b0;
    step("r and",  4'b0000, 3'b000, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b1);
    step("r add",  4'b0000, 3'b001, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b001, 16'h00F4, 1'b0);
    step("r sub",  4'b0000, 3'b010, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b010, 16'h00EC, 1'b0);
    step("r sll",  4'b0000, 3'b011, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b011, 16'h0F00, 1'b0);
    step("r srl",  4'b0000, 3'b100, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b100, 16'h000F, 1'b0);
    step("r or",   4'b0000, 3'b101, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b101, 16'h00F4, 1'b0);
    step("r slt",  4'b0000, 3'b110, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b110, 16'h0000, 1'b1);
    step("r f111", 4'b0000, 3'b111, 16'h00F0, 16'h0004, 16'h0, 1'b0, 1'b0, 3'b001, 16'h00F4, 1'b0);
    step("sll hi", 4'b0000, 3'b011, 16'h0001, 16'hFFF3, 16'h0, 1'b0, 1'b0, 3'b011, 16'h0008, 1'b0);
    step("srl 15", 4'b0000, 3'b100, 16'h8000, 16'h000F, 16'h0, 1'b0, 1'b0, 3'b100, 16'h0001, 1'b0);
    step("andi",   4'b0001, 3'b000, 16'h0F0F, 16'h0000, 16'h00FF, 1'b1, 1'b0, 3'b000, 16'h000F, 1'b0);
    step("addi",   4'b0010, 3'b000, 16'h0005, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 3'b001, 16'h0003, 1'b0);
    step("slt neg",4'b0000, 3'b110, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0, 3'b110, 16'h0001, 1'b0);
    step("lui",    4'b1000, 3'b000, 16'h1111, 16'h2222, 16'hAB00, 1'b1, 1'b0, 3'b111, 16'hAB00, 1'b0);
    step("sub 8k", 4'b0000, 3'b010, 16'h8000, 16'h8000, 16'h0, 1'b0, 1'b0, 3'b010, 16'h0000, 1'b1);
    step("beq",    4'b0101, 3'b000, 16'h7777, 16'h7777, 16'h0, 1'b0, 1'b0, 3'b010, 16'h0000, 1'b1);
    step("bne",    4'b0110, 3'b000, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b0, 3'b010, 16'hFFFF, 1'b0);
    step("lw",     4'b0011, 3'b000, 16'h1000, 16'h0000, 16'h0010, 1'b1, 1'b0, 3'b001, 16'h1010, 1'b0);
    step("sw",     4'b0100, 3'b000, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0, 3'b001, 16'h0000, 1'b1);
    step("for 3",  4'b0111, 3'b000, 16'h5555, 16'h0003, 16'h0, 1'b0, 1'b1, 3'b001, 16'h0002, 1'b0);
    step("for 1",  4'b0111, 3'b000, 16'h5555, 16'h0001, 16'h0, 1'b0, 1'b1, 3'b001, 16'h0000, 1'b1);
    step("for 0",  4'b0111, 3'b000, 16'h5555, 16'h0000, 16'h0, 1'b0, 1'b1, 3'b001, 16'hFFFF, 1'b0);
    step("jump",   4'b1010, 3'b101, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 3'b001, 16'h0005, 1'b0);
    io.pc = 16'h0000; #1;
    check("next_pc 0", io.next_pc, 16'h0001);
    io.pc = 16'hFFFF; #1;
    check("next_pc wrap", io.next_pc, 16'h0000);
    io.pc = 16'h1234; #1;
    check("next_pc mid", io.next_pc, 16'h1235);
    step("pre stall", 4'b0000, 3'b001, 16'h0100, 16'h0023, 16'h0, 1'b0, 1'b0, 3'b001, 16'h0123, 1'b0);
    io.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 3'b010, 16'h0040 + 16'(i), 16'h0040, 16'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("stall alu_y_q", io.alu_y_q, 16'h0123);
      check("stall zero_q", {15'd0, io.zero_q}, 16'h0000);
    end
    io.en = 1'b1;
    @(posedge clk); #1;
    check("resume alu_y_q", io.alu_y_q, 16'h0002);
    check("resume zero_q", {15'd0, io.zero_q}, 16'h0000);
    drive(4'b0000, 3'b010, 16'h0040, 16'h0040, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("resume zero_q set", {15'd0, io.zero_q}, 16'h0001);
    drive(4'b0000, 3'b001, 16'h4321, 16'h0000, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset alu_y_q", io.alu_y_q, 16'h0000);
    check("mid reset zero_q", {15'd0, io.zero_q}, 16'h0000);
    check("mid reset live y", io.alu_y, 16'h4321);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post reset alu_y_q", io.alu_y_q, 16'h4321);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
